// File: rtl/stage_pkg.sv
// rtl/stage_pkg.sv - stage encodings, role constants and width helper for stage_ctrl
// No ports: shared types and constants only.

package stage_pkg;

    typedef enum logic [1:0] {
        ST_MENU = 2'd0,
        ST_SYNC = 2'd1,
        ST_GAME = 2'd2,
        ST_OVER = 2'd3
    } stage_t;

    localparam logic ROLE_MASTER = 1'b0;
    localparam logic ROLE_SLAVE  = 1'b1;

    // finish_src encodes 0 = local board, k = channel k-1.
    function automatic int finish_src_w(input int n_peers);
        return $clog2(n_peers + 1);
    endfunction

endpackage

// File: rtl/click_edge.sv
// rtl/click_edge.sv - registered mouse release-edge detector
// Ports:
//   clk, reset    clock, asynchronous active-low reset
//   mouse_left    raw left-button level, 1 = pressed
//   click         one-cycle registered pulse on press-to-release transition

module click_edge (
    input  logic clk,
    input  logic reset,
    input  logic mouse_left,
    output logic click
);

    logic mouse_prev;

    // mouse_prev resets to 0 so a button held through reset does not
    // produce a release pulse when reset is lifted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mouse_prev <= 1'b0;
            click      <= 1'b0;
        end else begin
            mouse_prev <= mouse_left;
            click      <= mouse_prev & ~mouse_left;
        end
    end

endmodule

// File: rtl/stage_ctrl.sv
// rtl/stage_ctrl.sv - MENU/SYNC/GAME/OVER stage controller with peer start handshake
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   mouse_left                  raw left-button level
//   on_*_btn                    cursor-over-button flags (mutually exclusive)
//   game_finish                 local board solved
//   rx_connect/start/ack/finish per-channel one-cycle receive pulses
//   tx_connect/start/finish     one-cycle broadcast pulses
//   tx_ack                      per-channel one-cycle acknowledge pulse
//   stage, game_init            current stage, board init request (decoded)
//   role, peers_linked          master/slave role, linked-channel mask
//   finish_src                  first finisher: 0 local, k = channel k-1
//   link_error                  sticky ack-timeout flag

module stage_ctrl
    import stage_pkg::*;
#(
    parameter int N_PEERS     = 2,
    parameter int ACK_TIMEOUT = 10_000_000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           mouse_left,
    input  logic                           on_start_btn,
    input  logic                           on_connect_btn,
    input  logic                           on_return_btn,
    input  logic                           game_finish,
    input  logic [N_PEERS-1:0]             rx_connect,
    input  logic [N_PEERS-1:0]             rx_start,
    input  logic [N_PEERS-1:0]             rx_ack,
    input  logic [N_PEERS-1:0]             rx_finish,
    output logic                           tx_connect,
    output logic                           tx_start,
    output logic                           tx_finish,
    output logic [N_PEERS-1:0]             tx_ack,
    output logic [1:0]                     stage,
    output logic                           game_init,
    output logic                           role,
    output logic [N_PEERS-1:0]             peers_linked,
    output logic [$clog2(N_PEERS+1)-1:0]   finish_src,
    output logic                           link_error
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int IW = (N_PEERS > 1) ? $clog2(N_PEERS) : 1;
    localparam int FW = finish_src_w(N_PEERS);

    // Input sampling stage: every event is registered once so that the
    // click pulse, button flags and link pulses all reach the FSM aligned.
    logic               click_q;
    logic               start_q, connect_q, return_q, finish_q;
    logic [N_PEERS-1:0] rxc_q, rxs_q, rxa_q, rxf_q;

    click_edge u_click_edge (
        .clk        (clk),
        .reset      (reset),
        .mouse_left (mouse_left),
        .click      (click_q)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_q   <= 1'b0;
            connect_q <= 1'b0;
            return_q  <= 1'b0;
            finish_q  <= 1'b0;
            rxc_q     <= '0;
            rxs_q     <= '0;
            rxa_q     <= '0;
            rxf_q     <= '0;
        end else begin
            start_q   <= on_start_btn;
            connect_q <= on_connect_btn;
            return_q  <= on_return_btn;
            finish_q  <= game_finish;
            rxc_q     <= rx_connect;
            rxs_q     <= rx_start;
            rxa_q     <= rx_ack;
            rxf_q     <= rx_finish;
        end
    end

    logic start_click, connect_click, return_click;
    assign start_click   = click_q & start_q;
    assign connect_click = click_q & connect_q;
    assign return_click  = click_q & return_q;

    stage_t             stage_r, stage_nx;
    logic               role_nx, link_error_nx;
    logic [N_PEERS-1:0] peers_nx;
    logic [IW-1:0]      master_idx_r, master_idx_nx;
    logic [N_PEERS-1:0] acked_r, acked_nx;
    logic [TW-1:0]      timer_r, timer_nx;
    logic [FW-1:0]      finish_src_nx;
    logic               tx_connect_nx, tx_start_nx, tx_finish_nx;
    logic [N_PEERS-1:0] tx_ack_nx;

    // Lowest-index winners for simultaneous connects and remote finishes.
    logic [N_PEERS-1:0] rxf_hit;
    logic [IW-1:0]      conn_idx, fin_idx;
    logic               solo_link, all_acked;
    logic [N_PEERS-1:0] acked_sum;

    assign rxf_hit   = rxf_q & peers_linked;
    assign solo_link = (peers_linked == '0);
    assign acked_sum = acked_r | (rxa_q & peers_linked);
    assign all_acked = (acked_sum == peers_linked);

    always_comb begin
        conn_idx = '0;
        fin_idx  = '0;
        for (int i = N_PEERS - 1; i >= 0; i--) begin
            if (rxc_q[i])   conn_idx = IW'(i);
            if (rxf_hit[i]) fin_idx  = IW'(i);
        end
    end

    // State register: stage plus all registered status and tx pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage_r      <= ST_MENU;
            role         <= ROLE_MASTER;
            peers_linked <= '0;
            master_idx_r <= '0;
            acked_r      <= '0;
            timer_r      <= '0;
            finish_src   <= '0;
            link_error   <= 1'b0;
            tx_connect   <= 1'b0;
            tx_start     <= 1'b0;
            tx_finish    <= 1'b0;
            tx_ack       <= '0;
        end else begin
            stage_r      <= stage_nx;
            role         <= role_nx;
            peers_linked <= peers_nx;
            master_idx_r <= master_idx_nx;
            acked_r      <= acked_nx;
            timer_r      <= timer_nx;
            finish_src   <= finish_src_nx;
            link_error   <= link_error_nx;
            tx_connect   <= tx_connect_nx;
            tx_start     <= tx_start_nx;
            tx_finish    <= tx_finish_nx;
            tx_ack       <= tx_ack_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        stage_nx = stage_r;
        case (stage_r)
            ST_MENU: begin
                if (role == ROLE_MASTER) begin
                    // An incoming connect demotes us to slave and pre-empts a start click.
                    if (!(|rxc_q && solo_link) && start_click)
                        stage_nx = solo_link ? ST_GAME : ST_SYNC;
                end else if (rxs_q[master_idx_r]) begin
                    stage_nx = ST_GAME;
                end
            end
            ST_SYNC: begin
                if (all_acked)
                    stage_nx = ST_GAME;
                else if (timer_r == '0)
                    stage_nx = ST_MENU;
            end
            ST_GAME: begin
                if (finish_q || |rxf_hit)
                    stage_nx = ST_OVER;
            end
            ST_OVER: begin
                if (return_click)
                    stage_nx = ST_MENU;
            end
            default: stage_nx = ST_MENU;
        endcase
    end

    // Next-output logic: tx pulses default low so each lasts one cycle.
    always_comb begin
        role_nx       = role;
        peers_nx      = peers_linked;
        master_idx_nx = master_idx_r;
        acked_nx      = acked_r;
        timer_nx      = timer_r;
        finish_src_nx = finish_src;
        link_error_nx = link_error;
        tx_connect_nx = 1'b0;
        tx_start_nx   = 1'b0;
        tx_finish_nx  = 1'b0;
        tx_ack_nx     = '0;
        case (stage_r)
            ST_MENU: begin
                if (role == ROLE_MASTER) begin
                    if (connect_click) begin
                        tx_connect_nx = 1'b1;
                        link_error_nx = 1'b0;
                    end
                    if (|rxc_q && solo_link) begin
                        role_nx            = ROLE_SLAVE;
                        master_idx_nx      = conn_idx;
                        peers_nx           = '0;
                        peers_nx[conn_idx] = 1'b1;
                        tx_ack_nx          = '0;
                        tx_ack_nx[conn_idx] = 1'b1;
                    end else begin
                        peers_nx = peers_linked | rxa_q;
                        if (start_click && solo_link) begin
                            link_error_nx = 1'b0;
                        end else if (start_click) begin
                            tx_start_nx = 1'b1;
                            acked_nx    = '0;
                            timer_nx    = TW'(ACK_TIMEOUT);
                        end
                    end
                end else begin
                    if (rxs_q[master_idx_r]) begin
                        tx_ack_nx[master_idx_r] = 1'b1;
                        link_error_nx           = 1'b0;
                    end else if (return_click) begin
                        // Return is the only way out of a slave link.
                        role_nx  = ROLE_MASTER;
                        peers_nx = '0;
                    end
                end
            end
            ST_SYNC: begin
                acked_nx = acked_sum;
                if (all_acked)
                    link_error_nx = 1'b0;
                else if (timer_r == '0)
                    link_error_nx = 1'b1;
                else
                    timer_nx = timer_r - TW'(1);
            end
            ST_GAME: begin
                if (finish_q) begin
                    tx_finish_nx  = 1'b1;
                    finish_src_nx = '0;
                end else if (|rxf_hit) begin
                    finish_src_nx = FW'(fin_idx) + FW'(1);
                end
            end
            default: ;
        endcase
    end

    assign stage     = stage_r;
    assign game_init = (stage_r != ST_GAME);

endmodule

// File: tb/tb_stage_ctrl.sv
// tb/tb_stage_ctrl.sv - self-checking bench for stage_ctrl

module tb_stage_ctrl;

    localparam int NP = 2;
    localparam int AT = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          mouse_left = 1'b0;
    logic          on_start_btn = 1'b0, on_connect_btn = 1'b0, on_return_btn = 1'b0;
    logic          game_finish = 1'b0;
    logic [NP-1:0] rx_connect = '0, rx_start = '0, rx_ack = '0, rx_finish = '0;
    logic          tx_connect, tx_start, tx_finish;
    logic [NP-1:0] tx_ack;
    logic [1:0]    stage;
    logic          game_init, role, link_error;
    logic [NP-1:0] peers_linked;
    logic [1:0]    finish_src;

    int errors = 0;
    int checks = 0;

    stage_ctrl #(.N_PEERS(NP), .ACK_TIMEOUT(AT)) dut (
        .clk(clk), .reset(reset), .mouse_left(mouse_left),
        .on_start_btn(on_start_btn), .on_connect_btn(on_connect_btn),
        .on_return_btn(on_return_btn), .game_finish(game_finish),
        .rx_connect(rx_connect), .rx_start(rx_start), .rx_ack(rx_ack),
        .rx_finish(rx_finish), .tx_connect(tx_connect), .tx_start(tx_start),
        .tx_finish(tx_finish), .tx_ack(tx_ack), .stage(stage),
        .game_init(game_init), .role(role), .peers_linked(peers_linked),
        .finish_src(finish_src), .link_error(link_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // b: 0 start, 1 connect, 2 return. Returns right after the release is sampled.
    task automatic click(input int b);
        on_start_btn   = (b == 0);
        on_connect_btn = (b == 1);
        on_return_btn  = (b == 2);
        mouse_left = 1'b1;
        tick();
        mouse_left = 1'b0;
        tick();
        on_start_btn = 1'b0; on_connect_btn = 1'b0; on_return_btn = 1'b0;
    endtask

    task automatic check_reset_vals(input string p);
        chk({p, "_stage"}, 32'(stage), 0);
        chk({p, "_game_init"}, 32'(game_init), 1);
        chk({p, "_role"}, 32'(role), 0);
        chk({p, "_peers"}, 32'(peers_linked), 0);
        chk({p, "_tx"}, 32'({tx_connect, tx_start, tx_finish, tx_ack}), 0);
        chk({p, "_finish_src"}, 32'(finish_src), 0);
        chk({p, "_link_error"}, 32'(link_error), 0);
    endtask

    // Lowest set bit as finisher code, 0 if none.
    function automatic int first_src(input logic [NP-1:0] m);
        for (int i = 0; i < NP; i++) if (m[i]) return i + 1;
        return 0;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int t0, t1, tmax, dec, gf, rf, exp_src;
        logic ok;

        // Reset
        tick(); tick();
        check_reset_vals("reset");
        reset = 1'b1;
        tick();

        // Solo game
        click(0);
        chk("solo_pre_stage", 32'(stage), 0);
        tick();
        chk("solo_stage", 32'(stage), 2);
        chk("solo_game_init", 32'(game_init), 0);
        chk("solo_no_tx_start", 32'(tx_start), 0);
        game_finish = 1'b1; tick(); game_finish = 1'b0; tick();
        chk("solo_over", 32'(stage), 3);
        chk("solo_tx_finish", 32'(tx_finish), 1);
        chk("solo_finish_src", 32'(finish_src), 0);
        tick();
        chk("solo_tx_finish_once", 32'(tx_finish), 0);
        click(2); tick();
        chk("solo_return", 32'(stage), 0);

        // Link and start
        click(1); tick();
        chk("link_tx_connect", 32'(tx_connect), 1);
        tick();
        chk("link_tx_connect_once", 32'(tx_connect), 0);
        rx_ack = 2'b10; tick(); rx_ack = '0; tick();
        chk("link_peers", 32'(peers_linked), 2'b10);
        click(0); tick();
        chk("start_sync", 32'(stage), 1);
        chk("start_tx_start", 32'(tx_start), 1);
        tick();
        chk("start_tx_start_once", 32'(tx_start), 0);
        rx_ack = 2'b10; tick(); rx_ack = '0; tick();
        chk("start_game", 32'(stage), 2);
        game_finish = 1'b1; rx_finish = 2'b01; tick();
        game_finish = 1'b0; rx_finish = '0; tick();
        chk("race_stage", 32'(stage), 3);
        chk("race_src", 32'(finish_src), 0);
        chk("race_tx_finish", 32'(tx_finish), 1);
        click(2); tick();
        chk("race_return", 32'(stage), 0);
        chk("race_keep_peers", 32'(peers_linked), 2'b10);

        // Timeout with one of two peers acking
        rx_ack = 2'b01; tick(); rx_ack = '0; tick();
        chk("to_peers", 32'(peers_linked), 2'b11);
        click(0); tick();
        chk("to_sync", 32'(stage), 1);
        rx_ack = 2'b01; tick(); rx_ack = '0;
        for (int j = 2; j <= AT + 1; j++) begin
            tick();
            if (j == AT) chk("to_still_sync", 32'(stage), 1);
        end
        chk("to_menu", 32'(stage), 0);
        chk("to_link_error", 32'(link_error), 1);
        click(1); tick();
        chk("to_error_cleared", 32'(link_error), 0);

        // Randomized ack arrival and finish races, peers = 2'b11
        for (int tr = 0; tr < 8; tr++) begin
            t0 = $urandom_range(1, 12);
            t1 = $urandom_range(1, 12);
            if (tr == 0) begin t0 = AT; t1 = 3; end
            if (tr == 1) begin t0 = AT + 1; t1 = 1; end
            tmax = (t0 > t1) ? t0 : t1;
            ok   = (tmax <= AT);
            dec  = ok ? tmax + 1 : AT + 1;
            click(0); tick();
            chk("rnd_sync", 32'(stage), 1);
            for (int k = 1; k <= dec; k++) begin
                rx_ack = {t1 == k, t0 == k};
                tick();
                rx_ack = '0;
                if (k == dec - 1) chk("rnd_pending", 32'(stage), 1);
            end
            chk("rnd_outcome", 32'(stage), ok ? 2 : 0);
            chk("rnd_link_error", 32'(link_error), ok ? 0 : 1);
            if (ok) begin
                gf = $urandom_range(0, 1);
                rf = $urandom_range(0, 3);
                game_finish = gf[0]; rx_finish = rf[NP-1:0]; tick();
                game_finish = 1'b0; rx_finish = '0; tick();
                if (gf == 0 && rf == 0) begin
                    chk("rnd_no_finish", 32'(stage), 2);
                    game_finish = 1'b1; tick(); game_finish = 1'b0; tick();
                    exp_src = 0;
                end else begin
                    exp_src = (gf != 0) ? 0 : first_src(rf[NP-1:0]);
                    chk("rnd_tx_finish", 32'(tx_finish), 32'(gf));
                end
                chk("rnd_over", 32'(stage), 3);
                chk("rnd_src", 32'(finish_src), 32'(exp_src));
                click(2); tick();
                chk("rnd_return", 32'(stage), 0);
            end
        end

        // Reset mid-SYNC with the mouse held
        click(0); tick();
        chk("rst_sync", 32'(stage), 1);
        mouse_left = 1'b1;
        #2 reset = 1'b0;
        #1;
        check_reset_vals("rst_async");
        @(posedge clk); #1;
        reset = 1'b1;
        chk("rst_release_init", 32'(game_init), 1);
        tick(); tick();
        chk("rst_held_stage", 32'(stage), 0);
        chk("rst_held_init", 32'(game_init), 1);
        chk("rst_held_peers", 32'(peers_linked), 0);
        on_start_btn = 1'b1; mouse_left = 1'b0; tick();
        on_start_btn = 1'b0;
        chk("rst_click_init", 32'(game_init), 1);
        tick();
        chk("rst_fresh_click", 32'(stage), 2);
        game_finish = 1'b1; tick(); game_finish = 1'b0; tick();
        click(2); tick();
        chk("rst_back_menu", 32'(stage), 0);

        // Slave
        rx_connect = 2'b11; tick(); rx_connect = '0; tick();
        chk("slv_role", 32'(role), 1);
        chk("slv_peers", 32'(peers_linked), 2'b01);
        chk("slv_tx_ack", 32'(tx_ack), 2'b01);
        tick();
        chk("slv_tx_ack_once", 32'(tx_ack), 0);
        rx_start = 2'b10; tick(); rx_start = '0; tick();
        chk("slv_ignore_stage", 32'(stage), 0);
        chk("slv_ignore_ack", 32'(tx_ack), 0);
        rx_start = 2'b01; tick(); rx_start = '0; tick();
        chk("slv_start_ack", 32'(tx_ack), 2'b01);
        chk("slv_game", 32'(stage), 2);
        rx_finish = 2'b11; tick(); rx_finish = '0; tick();
        chk("slv_remote_over", 32'(stage), 3);
        chk("slv_remote_src", 32'(finish_src), 1);
        chk("slv_remote_no_tx", 32'(tx_finish), 0);
        click(2); tick();
        chk("slv_menu_role", 32'(role), 1);
        rx_start = 2'b01; tick(); rx_start = '0; tick();
        chk("slv_game2", 32'(stage), 2);
        game_finish = 1'b1; rx_finish = 2'b01; tick();
        game_finish = 1'b0; rx_finish = '0; tick();
        chk("slv_race_src", 32'(finish_src), 0);
        chk("slv_race_tx", 32'(tx_finish), 1);
        tick();
        chk("slv_race_tx_once", 32'(tx_finish), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stage_ctrl.md
# stage_ctrl

Parametrised game-stage controller for multi-board handwritten-sudoku play. Sequences MENU → SYNC → GAME → OVER from mouse-button clicks and link-receiver pulses from up to N_PEERS remote boards. Adds a start handshake with per-peer acknowledge, an ack timeout with a sticky error flag, and first-finisher reporting. Sits between the mouse/button hit-test logic and the link TX/RX blocks; drives game_init to the board logic.

## Interface
- N_PEERS, 2, number of link channels (1..4)
- ACK_TIMEOUT, 10_000_000, cycles SYNC waits for all acks
- TW, $clog2(ACK_TIMEOUT+1), timer width (derived, localparam)
- clk  in  1  system clock
- reset  in  1  **one clock; reset is asynchronous and active-low**: 0 resets immediately; released synchronously by the board reset logic
- mouse_left  in  1  raw left-button level, 1 = pressed
- on_start_btn, on_connect_btn, on_return_btn  in  1  cursor-over-button flags, mutually exclusive
- game_finish  in  1  local board solved, level
- rx_connect, rx_start, rx_ack, rx_finish  in  N_PEERS  one-cycle pulses per channel
- tx_connect, tx_start, tx_finish  out  1  one-cycle broadcast pulses
- tx_ack  out  N_PEERS  one-cycle pulse per channel
- stage  out  2  0 MENU, 1 SYNC, 2 GAME, 3 OVER
- game_init  out  1  1 in every stage except GAME
- role  out  1  0 master, 1 slave
- peers_linked  out  N_PEERS  linked-channel mask
- finish_src  out  $clog2(N_PEERS+1)  0 = local, k = channel k-1
- link_error  out  1  sticky ack-timeout flag

## Operation
- Click event: release edge; mouse_prev & ~mouse_left. Only clicks over a button act.
- MENU, master: connect click → tx_connect. rx_ack[i] → peers_linked[i]=1. rx_connect[i] while peers_linked==0 → role=slave, master_idx=i, peers_linked=onehot(i), tx_ack[i]. Simultaneous rx_connect: lowest i wins. rx_connect is ignored once any peer is linked.
- MENU, master, start click: if peers_linked==0 → GAME (solo). Otherwise → tx_start, acked=0, timer=ACK_TIMEOUT, then SYNC.
- MENU, slave: rx_start[master_idx] → tx_ack[master_idx], GAME. rx_start on other channels and all clicks except return are ignored.
- SYNC: acked |= rx_ack & peers_linked. When acked==peers_linked (including the same-cycle ack) → GAME. Otherwise timer decrements; at 0 → MENU with link_error=1. Clicks are ignored.
- GAME: game_finish → OVER, tx_finish, finish_src=0. Else rx_finish[i] & peers_linked[i] → OVER, finish_src=i+1, lowest i. Local finish beats same-cycle remote finish.
- OVER: return click → MENU. role, peers_linked and finish_src are retained.
- link_error clears on entering GAME or on a connect click.

## Timing
- All outputs are registered except game_init, which is decoded from stage.
- Event seen at edge k (input sampled) → stage/tx/status change visible after edge k+1.
- tx_* pulses last exactly one cycle and never repeat without a new event.
- Click latency: mouse_left 1 at edge k-1 and 0 at edge k → transition after edge k+1.
- Timeout: SYNC entered at edge s with no acks → MENU after edge s+ACK_TIMEOUT+1.
- Reset values: stage=MENU, game_init=1, role=0, peers_linked=0, all tx_*=0, finish_src=0, link_error=0, timer=0, acked=0, mouse_prev=0 (no spurious click while held through reset).
- Reset mid-SYNC/GAME returns to MENU immediately and drops the link (peers_linked=0).

## Structure
- stage_pkg: stage encodings, ROLE_MASTER/ROLE_SLAVE, finish_src width function.
- Sub-module click_edge: mouse_prev register plus release pulse, reset to 0.
- Timer, acked mask and FSM live in stage_ctrl.

## Test plan
(N_PEERS=2, ACK_TIMEOUT=8)
- Solo: start click in MENU with peers_linked=0 → stage=2 two edges after release, no tx_start.
- Link and start: connect click, rx_ack=2'b10 → peers_linked=2'b10. Start click → tx_start 1 cycle, stage=1; rx_ack=2'b10 → stage=2 next edge.
- Timeout: peers_linked=2'b11, only rx_ack=2'b01 → stage=0 at s+9, link_error=1. A connect click clears link_error.
- Slave: rx_connect=2'b11 same cycle → role=1, peers_linked=2'b01, tx_ack=2'b01. rx_start=2'b10 ignored; rx_start=2'b01 → tx_ack=2'b01, stage=2.
- Finish race: in GAME, game_finish=1 and rx_finish=2'b01 same cycle → stage=3, finish_src=0, tx_finish pulse. Rerun with rx_finish=2'b11 only → finish_src=1.
- Reset: reset=0 mid-SYNC with mouse_left held → all outputs at reset values immediately. After reset=1, releasing the mouse over start acts only as a fresh click, and game_init=1 throughout.
